// File: rtl/div_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Result is {remainder, quotient}; ready is held while start stays high.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 annul,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [WIDTH-1:0]     r_quo, w_quo;
    logic [WIDTH-1:0]     r_rem, w_rem;
    logic [WIDTH-1:0]     r_dvs, w_dvs;
    logic                 r_neg_q, w_neg_q;
    logic                 r_neg_r, w_neg_r;
    logic [2*WIDTH-1:0]   r_result, w_result;
    logic                 r_ready, w_ready;

    // Operand magnitudes; the most negative value maps onto itself as unsigned 2^(WIDTH-1)
    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;

    assign w_a_neg = signed_div & dividend[WIDTH-1];
    assign w_b_neg = signed_div & divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign w_b_mag = w_b_neg ? (~divisor + WIDTH'(1)) : divisor;

    // One restoring step: WIDTH+1-bit partial remainder against the divisor
    logic [WIDTH:0]       w_shift;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_q_fin, w_r_fin;
    logic [WIDTH-1:0]     w_q_fix, w_r_fix;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = WIDTH'(w_shift - {1'b0, r_dvs});
    assign w_q_fin = {r_quo[WIDTH-2:0], w_ge};
    assign w_r_fin = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_q_fix = r_neg_q ? (~w_q_fin + WIDTH'(1)) : w_q_fin;
    assign w_r_fix = r_neg_r ? (~w_r_fin + WIDTH'(1)) : w_r_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_quo    <= w_quo;
            r_rem    <= w_rem;
            r_dvs    <= w_dvs;
            r_neg_q  <= w_neg_q;
            r_neg_r  <= w_neg_r;
            r_result <= w_result;
            r_ready  <= w_ready;
        end
    end

    // Next-state and registered-output logic; annul overrides everything
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_quo    = r_quo;
        w_rem    = r_rem;
        w_dvs    = r_dvs;
        w_neg_q  = r_neg_q;
        w_neg_r  = r_neg_r;
        w_result = r_result;
        w_ready  = r_ready;

        if (annul) begin
            w_state  = IDLE;
            w_cnt    = '0;
            w_quo    = '0;
            w_rem    = '0;
            w_dvs    = '0;
            w_neg_q  = 1'b0;
            w_neg_r  = 1'b0;
            w_result = '0;
            w_ready  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_quo   = w_a_mag;
                        w_dvs   = w_b_mag;
                        w_rem   = '0;
                        w_cnt   = '0;
                        w_neg_q = w_a_neg ^ w_b_neg;
                        w_neg_r = w_a_neg;
                        w_state = (divisor == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    w_state  = END;
                    w_result = '0;
                    w_ready  = 1'b1;
                end
                ON: begin
                    w_quo = w_q_fin;
                    w_rem = w_r_fin;
                    w_cnt = r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        w_state  = END;
                        w_cnt    = '0;
                        w_result = {w_r_fix, w_q_fix};
                        w_ready  = 1'b1;
                    end
                end
                END: begin
                    if (!start) begin
                        w_state = IDLE;
                        w_ready = 1'b0;
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_ready = 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks of div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, asynchronous reset and the start/ready handshake.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           annul;
    logic           signed_div;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] result;
    logic           ready;

    int n_pass   = 0;
    int n_checks = 0;

    logic [63:0] res;
    int          lat;
    logic        late;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .result     (result),
        .ready      (ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic longint mag(input logic [31:0] v, input logic s);
        if (s && v[31]) return -longint'($signed(v));
        return longint'(v);
    endfunction

    // Launch one divide, wait for ready, then exercise hold and release
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [63:0] r, output int l);
        @(negedge clk);
        rst        = 1'b0;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        l = 0;
        while (l < 60) begin
            @(posedge clk);
            #1;
            l++;
            if (ready === 1'b1) break;
            if (scramble && l == 1) begin
                dividend   = $urandom;
                divisor    = $urandom;
                signed_div = ~sgn;
            end
        end
        r = result;
        @(posedge clk);
        #1;
        check("hold_ready", 64'(ready), 64'd1);
        check("hold_result", result, r);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(ready), 64'd0);
        check("drop_result", result, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        #12;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        repeat (2) @(posedge clk);

        do_div(1'b0, 32'd100, 32'd7, 1'b1, res, lat);
        check("lat_100_7", 64'(lat), 64'd33);
        check("res_100_7", res, {32'h0000_0002, 32'h0000_000E});

        do_div(1'b0, 32'h1234, 32'h0, 1'b0, res, lat);
        check("lat_div0", 64'(lat), 64'd2);
        check("res_div0", res, 64'd0);

        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, res, lat);
        check("lat_s_m7_2", 64'(lat), 64'd33);
        check("res_s_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat);
        check("res_s_ovf", res, {32'h0000_0000, 32'h8000_0000});

        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, res, lat);
        check("res_s_7_m2", res, {32'h0000_0001, 32'hFFFF_FFFD});

        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, res, lat);
        check("res_u_max_1", res, {32'h0000_0000, 32'hFFFF_FFFF});

        do_div(1'b0, 32'd5, 32'hFFFF_FFFF, 1'b0, res, lat);
        check("res_u_5_max", res, {32'h0000_0005, 32'h0000_0000});

        // Annul part-way through the iteration
        @(negedge clk);
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, 64'd0);
        late = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) late = 1'b1;
        end
        check("annul_no_late", 64'(late), 64'd0);

        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, res, lat);
        check("lat_after_annul", 64'(lat), 64'd33);
        check("res_after_annul", res, {32'h0000_000F, 32'h0FFF_FFFF});

        // Asynchronous reset in the middle of the iteration
        @(negedge clk);
        dividend = 32'h1234_5678;
        divisor  = 32'h11;
        start    = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_ready", 64'(ready), 64'd0);
        check("rst_async_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        late = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) late = 1'b1;
        end
        check("rst_no_late", 64'(late), 64'd0);

        // First edge after reset release samples start
        @(negedge clk);
        rst = 1'b1;
        do_div(1'b0, 32'd7, 32'd7, 1'b0, res, lat);
        check("lat_first_edge", 64'(lat), 64'd33);
        check("res_first_edge", res, {32'h0000_0000, 32'h0000_0001});

        // Random back-to-back divides against language division
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b, eq, er, q, r;
            logic        s;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = (i % 2) == 1;
            if (b == 32'd0) b = 32'd1;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if (s) begin
                eq = 32'($signed(a) / $signed(b));
                er = 32'($signed(a) % $signed(b));
            end else begin
                eq = a / b;
                er = a % b;
            end
            do_div(s, a, b, 1'b0, res, lat);
            q = res[31:0];
            r = res[63:32];
            check("rand_lat", 64'(lat), 64'd33);
            check("rand_res", res, {er, eq});
            check("rand_identity", 64'(32'(q * b + r)), 64'(a));
            check("rand_rem_bound", 64'(mag(r, s) < mag(b, s)), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
